// File: rtl/pfc_pwm_gen.sv
// Complementary dead-time PWM generator for the PFC stage, with period-synchronous duty update.
// Optional trip input enabled by defining PFC_PWM_FAULT_EN; default build ignores fault.
module pfc_pwm_gen #(
    parameter int unsigned PERIOD   = 200,
    parameter int unsigned DEADTIME = 4,
    parameter int unsigned MAX_DUTY = 190
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] duty_in,
    input  logic       fault,
    output logic       gate_hi,
    output logic       gate_lo,
    output logic       period_start,
    output logic [7:0] duty_active
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned DT_W  = 4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] DUTY_MAX = CNT_W'(MAX_DUTY);
    localparam logic [DT_W-1:0]  DT_LAST  = DT_W'(DEADTIME - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DT,
        ST_HI,
`ifdef PFC_PWM_FAULT_EN
        ST_LO,
        ST_FAULT
`else
        ST_LO
`endif
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] duty_sh;
    logic [CNT_W-1:0] duty_clamp;
    logic [DT_W-1:0]  dt_cnt;
    logic             cnt_wrap;
    logic             raw;

    assign cnt_wrap    = en && (cnt == CNT_LAST);
    assign duty_clamp  = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
    assign raw         = (cnt < duty_sh);
    assign duty_active = duty_sh;

`ifndef PFC_PWM_FAULT_EN
    logic unused_fault;
    assign unused_fault = fault;
`endif

    // Period counter; parked at zero while disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (!en || cnt_wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Shadow duty follows the command only while idle or at the period boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            duty_sh      <= '0;
            period_start <= 1'b0;
        end else begin
            if (!en || cnt_wrap) begin
                duty_sh <= duty_clamp;
            end
            period_start <= cnt_wrap;
        end
    end

    // Dead-time counter runs only while resident in DT.
    always_ff @(posedge clk) begin
        if (reset || (state != ST_DT)) begin
            dt_cnt <= '0;
        end else begin
            dt_cnt <= dt_cnt + DT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            gate_hi <= 1'b0;
            gate_lo <= 1'b0;
        end else begin
            state   <= state_nxt;
            gate_hi <= (state_nxt == ST_HI);
            gate_lo <= (state_nxt == ST_LO);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    state_nxt = ST_DT;
                end
            end
            ST_DT: begin
                if (dt_cnt == DT_LAST) begin
                    state_nxt = raw ? ST_HI : ST_LO;
                end
            end
            ST_HI: begin
                if (!raw) begin
                    state_nxt = ST_DT;
                end
            end
            ST_LO: begin
                if (raw) begin
                    state_nxt = ST_DT;
                end
            end
`ifdef PFC_PWM_FAULT_EN
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (!en) begin
            state_nxt = ST_IDLE;
        end
`ifdef PFC_PWM_FAULT_EN
        // A trip wins over everything, including a simultaneous disable.
        if (fault) begin
            state_nxt = ST_FAULT;
        end
`endif
    end

endmodule
